ps2_rx_ctrl: RTL and testbench
==============================

# ps2_rx_ctrl

Receive-side controller for the PS/2 keyboard/mouse port. It synchronizes and de-glitches the raw `ps2_clk_i`/`ps2_dat_i` pins and sequences 11-bit device-to-host frames through a receive state machine. Checked bytes are buffered in a small FIFO, and `irq_o` drives the port interrupt. It sits between the PS/2 pins and the APB register block, which supplies the enable, interrupt-enable, pop and error-clear controls.

## Interface
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, ≥2.
- `FILTER_LEN`, 4: consecutive equal samples required before a filtered pin changes; ≥2.
- `TIMEOUT_CYC`, 16'd20000: clk_i cycles with no PS/2 clock falling edge before a partial frame is abandoned.
- `clk_i  input  1  system clock`
- `rst_n_i  input  1  reset, asynchronous, active-low`
- `ps2_clk_i  input  1  raw PS/2 clock pin, asynchronous`
- `ps2_dat_i  input  1  raw PS/2 data pin, asynchronous`
- `en_i  input  1  receiver enable`
- `irq_en_i  input  1  interrupt enable`
- `rd_i  input  1  pop one byte from the FIFO`
- `clr_i  input  1  clear all sticky error flags`
- `dat_o  output  8  FIFO head byte; valid when vld_o=1`
- `vld_o  output  1  FIFO not empty`
- `cnt_o  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy`
- `par_err_o  output  1  sticky: odd-parity check failed`
- `frm_err_o  output  1  sticky: bad stop bit or timeout`
- `ovf_err_o  output  1  sticky: good byte dropped because FIFO full`
- `irq_o  output  1  interrupt, registered`

## Operation
- Reset values: synchronizer and filter state =1 (idle-high bus). State=IDLE, all counters=0, FIFO empty. Outputs: `dat_o`=0, `vld_o`=0, `cnt_o`=0, all error flags=0, `irq_o`=0.
- Input path: 2-flop synchronizer per pin. Each filter has a saturating counter; the filtered value flips only after FILTER_LEN consecutive cycles of the opposite synchronized value. A sample event (`fall`) is a 1-cycle pulse when the filtered clock goes 1→0. Data is taken from the filtered data line in the same cycle.
- FSM, advancing only on `fall`:
  - IDLE: data=0 → DATA with bit count 0; data=1 → stay in IDLE, no error.
  - DATA: shift the bit into the byte LSB-first. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP:
    - data=1 and parity good (XOR of the 8 data bits and the parity bit = 1): push the byte and go to IDLE.
    - data=0: set `frm_err_o` and go to IDLE; no push.
    - Parity bad (stop bit = 1): set `par_err_o` and go to IDLE; no push.
    - If both errors occur, both flags are set.
- Timeout: a watchdog counter clears on every `fall` and in IDLE, and increments in any other state. When it reaches TIMEOUT_CYC: set `frm_err_o`, discard the partial byte, go to IDLE.
- `en_i`=0: FSM is held in IDLE and the watchdog is cleared. Synchronizers, filters, FIFO contents and pops keep working. Dropping `en_i` mid-frame discards the frame with no error flag.
- FIFO: `dat_o` shows the head entry combinationally from registered storage. Pointers wrap modulo FIFO_DEPTH.
  - Pop with `rd_i`=1 and `vld_o`=1; `rd_i` while empty is ignored.
  - Push while full, without a same-cycle pop: byte dropped, `ovf_err_o` set.
  - Push and pop in the same cycle while full: both take effect; `cnt_o` unchanged, no overflow.
- Sticky flags: `clr_i` clears all three flags. A set event in the same cycle as `clr_i` wins, so the flag stays 1.
- `irq_o` next value = `irq_en_i` & (`vld_o` | `par_err_o` | `frm_err_o` | `ovf_err_o`). Level-type: it stays high until the FIFO is drained and the errors are cleared.

## Timing
- Pin to `fall`: 2 synchronizer cycles plus FILTER_LEN cycles after a stable low on `ps2_clk_i`.
- Stop-bit `fall` (cycle N) → push registered at N+1: `vld_o`/`cnt_o` update at N+1, `irq_o` at N+2.
- Pop: `rd_i` high at cycle M → `cnt_o`/`dat_o` reflect the new head at M+1.
- Error flags assert the cycle after the detecting `fall`, or the cycle after the watchdog hits TIMEOUT_CYC.
- Asynchronous reset mid-frame: immediate return to the reset values above. The partial frame is lost with no flag. Receive resumes at the next start bit after reset release.

## Test plan
- Frame 0xA5 with parity 1, stop 1, PS/2 clock at 1/64 clk_i → `dat_o`=0xA5, `cnt_o`=1, no errors. With `irq_en_i`=1, `irq_o`=1 two cycles after the stop `fall`. Pulse `rd_i` → `cnt_o`=0, and `irq_o` falls one cycle later.
- Frame 0x3C with parity 0 (wrong) → `par_err_o`=1, `cnt_o`=0. Then `clr_i` → flag 0. Next good 0x3C with parity 1 is received normally.
- Start bit plus 4 data bits, then the clock stops for TIMEOUT_CYC cycles → `frm_err_o`=1, state IDLE. A following good 0x12 frame is received as 0x12.
- Nine good frames 0x01..0x09 with FIFO_DEPTH=8 and no pops → `ovf_err_o`=1, `cnt_o`=8, pops return 0x01..0x08 in order. Repeat with a pop coincident with the 9th push → no overflow.
- Glitch test: (FILTER_LEN−1)-cycle low pulses on `ps2_clk_i` while idle → no `fall`, state stays IDLE, no flags.
- Reset test: assert `rst_n_i` after bit 5 of a frame → all outputs return to reset values. A good 0xFF frame with parity 1 after release → `dat_o`=0xFF.

Source files
------------

// File: rtl/ps2_rx_ctrl.sv
// rtl/ps2_rx_ctrl.sv - PS/2 device-to-host receive controller with filtering, frame FSM and RX FIFO
//
// Ports:
//   clk_i, rst_n_i          system clock, asynchronous active-low reset
//   ps2_clk_i, ps2_dat_i    raw asynchronous PS/2 pins
//   en_i                    receiver enable (0 holds the frame FSM in IDLE)
//   irq_en_i                interrupt enable
//   rd_i                    pop the FIFO head
//   clr_i                   clear the sticky error flags
//   dat_o, vld_o, cnt_o     FIFO head byte, not-empty, occupancy
//   par_err_o, frm_err_o,   sticky parity / framing-or-timeout / overflow flags
//   ovf_err_o
//   irq_o                   registered level interrupt
module ps2_rx_ctrl #(
    parameter int          FIFO_DEPTH  = 8,
    parameter int          FILTER_LEN  = 4,
    parameter logic [15:0] TIMEOUT_CYC = 16'd20000,
    localparam int         CW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          ps2_clk_i,
    input  logic          ps2_dat_i,
    input  logic          en_i,
    input  logic          irq_en_i,
    input  logic          rd_i,
    input  logic          clr_i,
    output logic [7:0]    dat_o,
    output logic          vld_o,
    output logic [CW-1:0] cnt_o,
    output logic          par_err_o,
    output logic          frm_err_o,
    output logic          ovf_err_o,
    output logic          irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Input synchronizers and glitch filters (idle-high bus)
    logic [1:0]    r_clk_s, r_dat_s;
    logic          r_clk_f, r_dat_f, r_clk_f_d;
    logic [FW-1:0] r_clk_fc, r_dat_fc;
    logic          w_fall;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_clk_s   <= 2'b11;
            r_dat_s   <= 2'b11;
            r_clk_f   <= 1'b1;
            r_dat_f   <= 1'b1;
            r_clk_f_d <= 1'b1;
            r_clk_fc  <= '0;
            r_dat_fc  <= '0;
        end else begin
            r_clk_s   <= {r_clk_s[0], ps2_clk_i};
            r_dat_s   <= {r_dat_s[0], ps2_dat_i};
            r_clk_f_d <= r_clk_f;
            // Filtered value flips on the FILTER_LEN-th consecutive disagreeing sample
            if (r_clk_s[1] == r_clk_f) begin
                r_clk_fc <= '0;
            end else if (r_clk_fc == FW'(FILTER_LEN - 1)) begin
                r_clk_f  <= r_clk_s[1];
                r_clk_fc <= '0;
            end else begin
                r_clk_fc <= r_clk_fc + FW'(1);
            end
            if (r_dat_s[1] == r_dat_f) begin
                r_dat_fc <= '0;
            end else if (r_dat_fc == FW'(FILTER_LEN - 1)) begin
                r_dat_f  <= r_dat_s[1];
                r_dat_fc <= '0;
            end else begin
                r_dat_fc <= r_dat_fc + FW'(1);
            end
        end
    end

    assign w_fall = r_clk_f_d & ~r_clk_f;

    // Frame FSM
    state_t      r_state, w_state_nx;
    logic [2:0]  r_bitc, w_bitc_nx;
    logic [7:0]  r_shift, w_shift_nx;
    logic        r_par, w_par_nx;
    logic [15:0] r_wdog, w_wdog_nx;
    logic        w_push, w_set_par, w_set_frm, w_par_ok;

    assign w_par_ok = ^{r_shift, r_par};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_bitc  <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_bitc  <= w_bitc_nx;
            r_shift <= w_shift_nx;
            r_par   <= w_par_nx;
            r_wdog  <= w_wdog_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_bitc_nx  = r_bitc;
        w_shift_nx = r_shift;
        w_par_nx   = r_par;
        w_wdog_nx  = (r_state == S_IDLE) ? 16'd0 : r_wdog + 16'd1;
        w_push     = 1'b0;
        w_set_par  = 1'b0;
        w_set_frm  = 1'b0;
        if (!en_i) begin
            // Disabling abandons any partial frame silently
            w_state_nx = S_IDLE;
            w_wdog_nx  = 16'd0;
        end else if (w_fall) begin
            w_wdog_nx = 16'd0;
            case (r_state)
                S_IDLE: begin
                    if (!r_dat_f) begin
                        w_state_nx = S_DATA;
                        w_bitc_nx  = 3'd0;
                    end
                end
                S_DATA: begin
                    w_shift_nx = {r_dat_f, r_shift[7:1]};
                    w_bitc_nx  = r_bitc + 3'd1;
                    if (r_bitc == 3'd7) begin
                        w_state_nx = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_par_nx   = r_dat_f;
                    w_state_nx = S_STOP;
                end
                S_STOP: begin
                    w_set_frm  = ~r_dat_f;
                    w_set_par  = ~w_par_ok;
                    w_push     = r_dat_f & w_par_ok;
                    w_state_nx = S_IDLE;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end else if (r_state != S_IDLE && r_wdog == TIMEOUT_CYC) begin
            w_set_frm  = 1'b1;
            w_state_nx = S_IDLE;
            w_wdog_nx  = 16'd0;
        end
    end

    // Receive FIFO
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_vld, w_full, w_do_pop, w_do_push, w_ovf;

    assign w_vld     = (r_cnt != '0);
    assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
    assign w_do_pop  = rd_i & w_vld;
    assign w_do_push = w_push & (~w_full | w_do_pop);
    assign w_ovf     = w_push & w_full & ~w_do_pop;

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky flags (a set event beats a same-cycle clear) and interrupt
    logic r_par_err, r_frm_err, r_ovf_err, r_irq;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovf_err <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_par_err <= w_set_par | (r_par_err & ~clr_i);
            r_frm_err <= w_set_frm | (r_frm_err & ~clr_i);
            r_ovf_err <= w_ovf     | (r_ovf_err & ~clr_i);
            r_irq     <= irq_en_i & (w_vld | r_par_err | r_frm_err | r_ovf_err);
        end
    end

    // Storage is not reset, so the head is masked while empty
    assign dat_o     = w_vld ? r_mem[r_rptr] : 8'h00;
    assign vld_o     = w_vld;
    assign cnt_o     = r_cnt;
    assign par_err_o = r_par_err;
    assign frm_err_o = r_frm_err;
    assign ovf_err_o = r_ovf_err;
    assign irq_o     = r_irq;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb/tb_ps2_rx_ctrl.sv - randomized self-checking bench for ps2_rx_ctrl
module tb_ps2_rx_ctrl;

    localparam int          DEPTH = 8;
    localparam int          FLEN  = 4;
    localparam logic [15:0] TOUT  = 16'd1000;
    localparam int          HALF  = 32;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_dat_i = 1'b1;
    logic       en_i = 1'b1;
    logic       irq_en_i = 1'b1;
    logic       rd_i = 1'b0;
    logic       clr_i = 1'b0;
    logic [7:0] dat_o;
    logic       vld_o;
    logic [3:0] cnt_o;
    logic       par_err_o, frm_err_o, ovf_err_o, irq_o;

    ps2_rx_ctrl #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
        .en_i(en_i), .irq_en_i(irq_en_i), .rd_i(rd_i), .clr_i(clr_i),
        .dat_o(dat_o), .vld_o(vld_o), .cnt_o(cnt_o),
        .par_err_o(par_err_o), .frm_err_o(frm_err_o), .ovf_err_o(ovf_err_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of accepted bytes plus sticky flags
    logic [7:0] m_q[$];
    logic       m_par = 1'b0, m_frm = 1'b0, m_ovf = 1'b0;
    int         lat_c, lat_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cnt"}, cnt_o, m_q.size());
        chk({tag, ".vld"}, vld_o, m_q.size() != 0);
        chk({tag, ".dat"}, dat_o, (m_q.size() != 0) ? m_q[0] : 8'h00);
        chk({tag, ".par"}, par_err_o, m_par);
        chk({tag, ".frm"}, frm_err_o, m_frm);
        chk({tag, ".ovf"}, ovf_err_o, m_ovf);
        chk({tag, ".irq"}, irq_o, irq_en_i & ((m_q.size() != 0) | m_par | m_frm | m_ovf));
    endtask

    task automatic pop_check(input string tag);
        chk({tag, ".pop"}, dat_o, m_q[0]);
        @(posedge clk_i); #1 rd_i = 1'b1;
        @(posedge clk_i); #1 rd_i = 1'b0;
        void'(m_q.pop_front());
    endtask

    task automatic drain(input string tag);
        while (m_q.size() != 0) pop_check(tag);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_flags();
        @(posedge clk_i); #1 clr_i = 1'b1;
        @(posedge clk_i); #1 clr_i = 1'b0;
        m_par = 1'b0; m_frm = 1'b0; m_ovf = 1'b0;
    endtask

    // mode 0: plain; 1: pop coincident with the stop-bit push; 2: measure push/irq latency
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int nbits, input int mode);
        logic [10:0] bits;
        bits  = {s, p, d, 1'b0};
        lat_c = -1;
        lat_i = -1;
        @(posedge clk_i); #1;
        for (int i = 0; i < nbits; i++) begin
            ps2_dat_i = bits[i];
            repeat (HALF) @(posedge clk_i);
            #1 ps2_clk_i = 1'b0;
            for (int c = 0; c < HALF; c++) begin
                @(posedge clk_i); #1;
                if (mode == 1 && i == 10) rd_i = (c == FLEN + 1);
                if (mode == 2 && i == 10) begin
                    if (lat_c < 0 && cnt_o != 4'd0) lat_c = c;
                    if (lat_i < 0 && irq_o)         lat_i = c;
                end
            end
            ps2_clk_i = 1'b1;
        end
        ps2_dat_i = 1'b1;
        repeat (40) @(posedge clk_i);
        #1;
        if (nbits == 11) begin
            if (!s)              m_frm = 1'b1;
            if ((^d ^ p) != 1'b1) m_par = 1'b1;
            if (s && ((^d ^ p) == 1'b1)) begin
                if (mode == 1 && m_q.size() != 0) void'(m_q.pop_front());
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else                    m_ovf = 1'b1;
            end
        end
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check_all("reset");
        rst_n_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;

        // Frame 0xA5 with latency measurement, then pop and irq fall
        send_frame(8'hA5, 1'b1, 1'b1, 11, 2);
        chk("a5.push_lat", lat_c, FLEN + 2);
        chk("a5.irq_lat", lat_i, FLEN + 3);
        check_all("a5");
        @(posedge clk_i); #1 rd_i = 1'b1;
        @(posedge clk_i); #1 rd_i = 1'b0;
        void'(m_q.pop_front());
        chk("a5.cnt_after_pop", cnt_o, 0);
        chk("a5.irq_lag", irq_o, 1);
        @(posedge clk_i); #1;
        chk("a5.irq_fall", irq_o, 0);

        // Parity error, clear, good retry
        send_frame(8'h3C, 1'b0, 1'b1, 11, 0);
        check_all("3c_bad");
        clear_flags();
        @(posedge clk_i); #1;
        check_all("3c_clr");
        send_frame(8'h3C, 1'b1, 1'b1, 11, 0);
        check_all("3c_good");
        drain("3c");

        // Timeout on a partial frame, then a good frame
        send_frame(8'h0F, 1'b0, 1'b1, 5, 0);
        repeat (int'(TOUT) + 100) @(posedge clk_i);
        #1;
        m_frm = 1'b1;
        check_all("tout");
        clear_flags();
        send_frame(8'h12, odd_par(8'h12), 1'b1, 11, 0);
        check_all("tout_next");
        drain("tout");

        // Enable drop mid-frame discards silently
        send_frame(8'hC3, 1'b0, 1'b1, 5, 0);
        en_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1 en_i = 1'b1;
        repeat (int'(TOUT) + 20) @(posedge clk_i);
        #1;
        check_all("en_drop");
        send_frame(8'h77, odd_par(8'h77), 1'b1, 11, 0);
        check_all("en_next");
        drain("en");

        // Overflow: nine frames without pops
        for (int k = 1; k <= 9; k++) send_frame(8'(k), odd_par(8'(k)), 1'b1, 11, 0);
        check_all("ovf");
        drain("ovf");
        clear_flags();

        // Pop coincident with the ninth push: no overflow
        for (int k = 1; k <= 8; k++) send_frame(8'(k), odd_par(8'(k)), 1'b1, 11, 0);
        send_frame(8'h09, odd_par(8'h09), 1'b1, 11, 1);
        check_all("ovf_pop");
        drain("ovf_pop");

        // Glitches shorter than the filter length
        for (int g = 0; g < 5; g++) begin
            @(posedge clk_i); #1 ps2_clk_i = 1'b0;
            repeat (FLEN - 1) @(posedge clk_i);
            #1 ps2_clk_i = 1'b1;
            repeat (10) @(posedge clk_i);
        end
        #1;
        check_all("glitch");
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 11, 0);
        check_all("glitch_next");
        drain("glitch");

        // Randomized frames with random errors, pops and clears
        for (int it = 0; it < 14; it++) begin
            logic [7:0] d;
            logic       pbad, sbad;
            int         npop;
            d    = 8'($urandom);
            pbad = ($urandom % 4) == 0;
            sbad = ($urandom % 5) == 0;
            send_frame(d, odd_par(d) ^ pbad, ~sbad, 11, 0);
            check_all("rnd");
            npop = $urandom % 3;
            for (int j = 0; j < npop && m_q.size() != 0; j++) pop_check("rnd");
            if (($urandom % 3) == 0) clear_flags();
            repeat (2) @(posedge clk_i);
            #1;
            check_all("rnd_post");
        end
        drain("rnd");
        clear_flags();

        // Asynchronous reset mid-frame with data buffered
        send_frame(8'h44, odd_par(8'h44), 1'b1, 11, 0);
        send_frame(8'h66, 1'b0, 1'b1, 6, 0);
        #3 rst_n_i = 1'b0;
        #2;
        m_q.delete();
        m_par = 1'b0; m_frm = 1'b0; m_ovf = 1'b0;
        check_all("async_rst");
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        send_frame(8'hFF, 1'b1, 1'b1, 11, 0);
        check_all("rst_next");
        drain("rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
